// File: rtl/load_store_unit_pkg.sv
// Shared ISA types for the load/store path: register index, memory-op control,
// LSU state encoding and the byte-lane helpers used for store steering and load extraction.
package load_store_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef logic [REG_W-1:0] rv_reg_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_width_t;

  typedef struct packed {
    mem_width_t      width;
    logic            r_sign_extend;
    logic            w_enable;
    logic [XLEN-1:0] w_value;
  } compute_mem_control_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  function automatic logic [STRB_W-1:0] lane_wstrb(input mem_width_t width, input logic [1:0] addr_lo);
    case (width)
      MEM_BYTE: return STRB_W'(4'b0001 << addr_lo);
      MEM_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_wdata(input mem_width_t width, input logic [XLEN-1:0] value);
    case (width)
      MEM_BYTE: return {4{value[7:0]}};
      MEM_HALF: return {2{value[15:0]}};
      default:  return value;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_extract(input mem_width_t width, input logic sign_ext,
                                                   input logic [1:0] addr_lo, input logic [XLEN-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (width)
      MEM_BYTE: return {{(XLEN-8){sign_ext & b[7]}}, b};
      MEM_HALF: return {{(XLEN-16){sign_ext & h[15]}}, h};
      default:  return rdata;
    endcase
  endfunction

  function automatic logic lane_misaligned(input mem_width_t width, input logic [1:0] addr_lo);
    case (width)
      MEM_HALF: return addr_lo[0];
      MEM_WORD: return |addr_lo;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store strobes and replicated write data, plus
// load byte/halfword extraction with sign or zero extension.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]        i_addr_lo,
  input  mem_width_t        i_width,
  input  logic              i_sign_extend,
  input  logic [XLEN-1:0]   i_w_value,
  input  logic [XLEN-1:0]   i_rdata,
  output logic [STRB_W-1:0] o_wstrb_c,
  output logic [XLEN-1:0]   o_wdata_c,
  output logic [XLEN-1:0]   o_load_data_c
);

  assign o_wstrb_c     = lane_wstrb(i_width, i_addr_lo);
  assign o_wdata_c     = lane_wdata(i_width, i_w_value);
  assign o_load_data_c = lane_extract(i_width, i_sign_extend, i_addr_lo, i_rdata);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging the execute stage to a word-wide data bus.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word ops fault instead of being force-aligned.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [XLEN-1:0]      req_addr,
  input  compute_mem_control_t req_mem,
  input  rv_reg_t              req_rd,
  output logic                 bus_valid,
  input  logic                 bus_ready,
  output logic [XLEN-1:0]      bus_addr,
  output logic                 bus_we,
  output logic [STRB_W-1:0]    bus_wstrb,
  output logic [XLEN-1:0]      bus_wdata,
  input  logic                 bus_rvalid,
  input  logic [XLEN-1:0]      bus_rdata,
  output logic                 resp_valid,
  output logic                 resp_rd_enable,
  output rv_reg_t              resp_rd,
  output logic [XLEN-1:0]      resp_data,
  output logic                 fault_misaligned
);

  lsu_state_t           r_state, w_state_n;
  logic [XLEN-1:0]      r_addr, w_addr_n;
  compute_mem_control_t r_mem, w_mem_n;
  rv_reg_t              r_rd, w_rd_n;
  logic                 r_fault, w_fault_n;
  logic                 w_misalign, w_capture;
  logic                 w_in_req, w_in_resp, w_store_req, w_resp_load;
  logic [STRB_W-1:0]    w_wstrb;
  logic [XLEN-1:0]      w_wdata, w_load_data;

  logic                 r_req_ready, r_bus_valid, r_bus_we, r_resp_valid, r_resp_rd_enable;
  logic [XLEN-1:0]      r_bus_addr, r_bus_wdata, r_resp_data;
  logic [STRB_W-1:0]    r_bus_wstrb;
  rv_reg_t              r_resp_rd;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = lane_misaligned(req_mem.width, req_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  // Lane logic sees the next-cycle request so the bus outputs can be registered.
  lsu_lane_align u_lane_align (
    .i_addr_lo     (w_addr_n[1:0]),
    .i_width       (w_mem_n.width),
    .i_sign_extend (w_mem_n.r_sign_extend),
    .i_w_value     (w_mem_n.w_value),
    .i_rdata       (bus_rdata),
    .o_wstrb_c     (w_wstrb),
    .o_wdata_c     (w_wdata),
    .o_load_data_c (w_load_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_mem   <= '0;
      r_rd    <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_addr  <= w_addr_n;
      r_mem   <= w_mem_n;
      r_rd    <= w_rd_n;
      r_fault <= w_fault_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_addr_n  = r_addr;
    w_mem_n   = r_mem;
    w_rd_n    = r_rd;
    w_fault_n = r_fault;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_addr_n  = req_addr;
          w_mem_n   = req_mem;
          w_rd_n    = req_rd;
          w_fault_n = w_misalign;
          w_state_n = w_misalign ? RESP : REQ;
        end
      end
      REQ: begin
        if (bus_ready) begin
          if (r_mem.w_enable) begin
            w_state_n = RESP;
          end else if (bus_rvalid) begin
            w_capture = 1'b1;
            w_state_n = RESP;
          end else begin
            w_state_n = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (bus_rvalid) begin
          w_capture = 1'b1;
          w_state_n = RESP;
        end
      end
      RESP: begin
        w_fault_n = 1'b0;
        w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign w_in_req    = (w_state_n == REQ);
  assign w_in_resp   = (w_state_n == RESP);
  assign w_store_req = w_in_req && w_mem_n.w_enable;
  assign w_resp_load = w_in_resp && !w_mem_n.w_enable && !w_fault_n;

  // Outputs are registered images of the next state and the request it carries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_ready      <= 1'b1;
      r_bus_valid      <= 1'b0;
      r_bus_addr       <= '0;
      r_bus_we         <= 1'b0;
      r_bus_wstrb      <= '0;
      r_bus_wdata      <= '0;
      r_resp_valid     <= 1'b0;
      r_resp_rd_enable <= 1'b0;
      r_resp_rd        <= '0;
      r_resp_data      <= '0;
    end else begin
      r_req_ready      <= (w_state_n == IDLE);
      r_bus_valid      <= w_in_req;
      r_bus_addr       <= w_in_req ? {w_addr_n[XLEN-1:2], 2'b00} : '0;
      r_bus_we         <= w_store_req;
      r_bus_wstrb      <= w_store_req ? w_wstrb : '0;
      r_bus_wdata      <= w_store_req ? w_wdata : '0;
      r_resp_valid     <= w_in_resp;
      r_resp_rd_enable <= w_resp_load;
      r_resp_rd        <= w_resp_load ? w_rd_n : '0;
      r_resp_data      <= w_capture ? w_load_data : '0;
    end
  end

  assign req_ready      = r_req_ready;
  assign bus_valid      = r_bus_valid;
  assign bus_addr       = r_bus_addr;
  assign bus_we         = r_bus_we;
  assign bus_wstrb      = r_bus_wstrb;
  assign bus_wdata      = r_bus_wdata;
  assign resp_valid     = r_resp_valid;
  assign resp_rd_enable = r_resp_rd_enable;
  assign resp_rd        = r_resp_rd;
  assign resp_data      = r_resp_data;

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_fault_pulse;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_fault_pulse <= 1'b0;
    else          r_fault_pulse <= w_in_resp && w_fault_n;
  end
  assign fault_misaligned = r_fault_pulse;
`else
  assign fault_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized ops
// checked against an arithmetic model of the lane, extension and latency rules.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic                 clk, reset_n;
  logic                 req_valid, req_ready;
  logic [31:0]          req_addr;
  compute_mem_control_t req_mem;
  rv_reg_t              req_rd;
  logic                 bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [31:0]          bus_addr, bus_wdata, bus_rdata;
  logic [3:0]           bus_wstrb;
  logic                 resp_valid, resp_rd_enable, fault_misaligned;
  rv_reg_t              resp_rd;
  logic [31:0]          resp_data;

  int n_checks = 0;
  int n_pass   = 0;

  // observations of the last transaction
  logic [31:0] o_addr, o_wdata, o_resp_data;
  logic [3:0]  o_wstrb;
  logic        o_we, o_rd_en, o_fault, o_fault_extra, o_unstable, o_ready_hi;
  logic        o_bus_seen, o_timeout, o_after_ok, o_ready_at_accept;
  rv_reg_t     o_rd;
  int          o_lat;

  load_store_unit dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_mem(req_mem), .req_rd(req_rd),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_rd_enable(resp_rd_enable), .resp_rd(resp_rd),
    .resp_data(resp_data), .fault_misaligned(fault_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] m_wstrb(input int w, input logic [31:0] a);
    if (w == 0) return 4'(1 << (a % 4));
    if (w == 1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int w, input logic [31:0] v);
    if (w == 0) return (v & 32'hFF) * 32'h01010101;
    if (w == 1) return (v & 32'hFFFF) * 32'h00010001;
    return v;
  endfunction

  function automatic logic [31:0] m_load(input int w, input logic s, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] v;
    if (w == 0) begin
      v = (d >> (8 * (a % 4))) & 32'hFF;
      if (s && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (w == 1) begin
      v = (d >> (((a % 4) >= 2) ? 16 : 0)) & 32'hFFFF;
      if (s && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic m_misaligned(input int w, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return (w == 1 && (a % 2) != 0) || (w == 2 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- transaction driver (records observations only) ----------------
  task automatic run_op(input int w, input logic sgn, input logic we, input logic [31:0] addr,
                        input logic [31:0] wval, input rv_reg_t rd, input logic [31:0] rdata,
                        input int rdy_dly, input int rv_dly, input logic same);
    int   stall, wcnt, cyc;
    logic hs, rvd, done;
    stall = 0; wcnt = 0; cyc = 1; hs = 0; rvd = 0; done = 0;
    o_addr = '0; o_wdata = '0; o_wstrb = '0; o_we = 0; o_resp_data = '0; o_rd_en = 0; o_rd = '0;
    o_fault = 0; o_fault_extra = 0; o_unstable = 0; o_ready_hi = 0; o_bus_seen = 0;
    o_timeout = 0; o_after_ok = 0; o_lat = -1;
    @(posedge clk); #1;
    o_ready_at_accept = req_ready;
    req_valid = 1'b1;
    req_addr = addr;
    req_mem.width = mem_width_t'(w);
    req_mem.r_sign_extend = sgn;
    req_mem.w_enable = we;
    req_mem.w_value = wval;
    req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom;
    req_mem.w_value = $urandom;
    req_rd = rv_reg_t'($urandom);
    while (!done && cyc <= 60) begin
      bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
      if (resp_valid) begin
        done = 1; o_lat = cyc;
        o_resp_data = resp_data; o_rd_en = resp_rd_enable; o_rd = resp_rd; o_fault = fault_misaligned;
        bus_rvalid = 1'b1;
      end else begin
        if (req_ready) o_ready_hi = 1;
        if (fault_misaligned) o_fault_extra = 1;
        if (bus_valid) begin
          if (!o_bus_seen) begin
            o_addr = bus_addr; o_we = bus_we; o_wstrb = bus_wstrb; o_wdata = bus_wdata;
          end else if (bus_addr !== o_addr || bus_we !== o_we || bus_wstrb !== o_wstrb || bus_wdata !== o_wdata) begin
            o_unstable = 1;
          end
          o_bus_seen = 1;
          if (stall >= rdy_dly) begin
            bus_ready = 1'b1; hs = 1;
            if (!we && same) begin bus_rvalid = 1'b1; bus_rdata = rdata; rvd = 1; end
          end
          stall++;
        end else if (hs && !we && !rvd) begin
          if (wcnt >= rv_dly) begin bus_rvalid = 1'b1; bus_rdata = rdata; rvd = 1; end
          wcnt++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    if (!done) begin
      o_timeout = 1;
      reset_n = 1'b0; #2; reset_n = 1'b1;
    end else begin
      o_after_ok = !resp_valid && req_ready && !fault_misaligned;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; req_valid = 0; req_addr = '0; req_mem = '0; req_rd = '0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = '0;
    #12;
    n_checks++;
    if ({req_ready, bus_valid, bus_we, resp_valid, resp_rd_enable, fault_misaligned} !== 6'b100000)
      $display("FAIL reset_ctrl got=%b exp=100000", {req_ready, bus_valid, bus_we, resp_valid, resp_rd_enable, fault_misaligned});
    else n_pass++;
    n_checks++;
    if ({bus_addr, bus_wdata, bus_wstrb, resp_data, resp_rd} !== '0)
      $display("FAIL reset_data got addr=%h wdata=%h wstrb=%b data=%h rd=%0d", bus_addr, bus_wdata, bus_wstrb, resp_data, resp_rd);
    else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_store_byte();
    run_op(0, 1'b0, 1'b1, 32'h1003, 32'h000000AB, 5'd5, 32'h0, 0, 0, 1'b0);
    n_checks++; if (o_timeout !== 1'b0) $display("FAIL sb_timeout"); else n_pass++;
    n_checks++; if (o_ready_at_accept !== 1'b1) $display("FAIL sb_ready got=%b exp=1", o_ready_at_accept); else n_pass++;
    n_checks++; if (o_addr !== 32'h1000) $display("FAIL sb_addr got=%h exp=00001000", o_addr); else n_pass++;
    n_checks++; if (o_we !== 1'b1) $display("FAIL sb_we got=%b exp=1", o_we); else n_pass++;
    n_checks++; if (o_wstrb !== 4'b1000) $display("FAIL sb_wstrb got=%b exp=1000", o_wstrb); else n_pass++;
    n_checks++; if (o_wdata !== 32'hABABABAB) $display("FAIL sb_wdata got=%h exp=abababab", o_wdata); else n_pass++;
    n_checks++; if (o_lat !== 2) $display("FAIL sb_latency got=%0d exp=2", o_lat); else n_pass++;
    n_checks++; if ({o_rd_en, o_resp_data} !== 33'h0) $display("FAIL sb_resp got en=%b data=%h exp 0", o_rd_en, o_resp_data); else n_pass++;
    n_checks++; if (o_after_ok !== 1'b1) $display("FAIL sb_pulse got=%b exp=1", o_after_ok); else n_pass++;
  endtask

  task automatic test_load_byte();
    run_op(0, 1'b1, 1'b0, 32'h2002, 32'h0, 5'd7, 32'h00800000, 0, 0, 1'b0);
    n_checks++; if (o_resp_data !== 32'hFFFFFF80) $display("FAIL lb_data got=%h exp=ffffff80", o_resp_data); else n_pass++;
    n_checks++; if ({o_rd_en, o_rd} !== {1'b1, 5'd7}) $display("FAIL lb_rd got en=%b rd=%0d exp en=1 rd=7", o_rd_en, o_rd); else n_pass++;
    n_checks++; if ({o_addr, o_we, o_wstrb, o_wdata} !== {32'h2000, 1'b0, 4'h0, 32'h0})
      $display("FAIL lb_bus got addr=%h we=%b wstrb=%b wdata=%h exp 2000/0/0/0", o_addr, o_we, o_wstrb, o_wdata); else n_pass++;
    run_op(0, 1'b0, 1'b0, 32'h2002, 32'h0, 5'd7, 32'h00800000, 0, 0, 1'b0);
    n_checks++; if (o_resp_data !== 32'h00000080) $display("FAIL lbu_data got=%h exp=00000080", o_resp_data); else n_pass++;
  endtask

  task automatic test_load_half_stall();
    logic [31:0] d;
    d = {16'h8001, 16'($urandom)};
    run_op(1, 1'b1, 1'b0, 32'h2002, 32'h0, 5'd9, d, 3, 1, 1'b0);
    n_checks++; if (o_unstable !== 1'b0) $display("FAIL lh_stable got unstable=%b exp=0", o_unstable); else n_pass++;
    n_checks++; if (o_ready_hi !== 1'b0) $display("FAIL lh_ready_low got high=%b exp=0", o_ready_hi); else n_pass++;
    n_checks++; if (o_resp_data !== 32'hFFFF8001) $display("FAIL lh_data got=%h exp=ffff8001", o_resp_data); else n_pass++;
    n_checks++; if (o_lat !== 7) $display("FAIL lh_latency got=%0d exp=7", o_lat); else n_pass++;
    n_checks++; if (o_addr !== 32'h2000) $display("FAIL lh_addr got=%h exp=00002000", o_addr); else n_pass++;
  endtask

  task automatic test_load_word_same_cycle();
    run_op(2, 1'b0, 1'b0, 32'h3000, 32'h0, 5'd3, 32'h12345678, 0, 0, 1'b1);
    n_checks++; if (o_resp_data !== 32'h12345678) $display("FAIL lw_data got=%h exp=12345678", o_resp_data); else n_pass++;
    n_checks++; if (o_lat !== 2) $display("FAIL lw_skip_wait got=%0d exp=2", o_lat); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h4000; req_mem.width = MEM_WORD; req_mem.w_enable = 1'b0; req_rd = 5'd4;
    @(posedge clk); #1;
    req_valid = 1'b0; bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    n_checks++; if ({bus_valid, req_ready} !== 2'b00) $display("FAIL wait_r_state got valid/ready=%b exp=00", {bus_valid, req_ready}); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if ({req_ready, resp_valid, bus_valid} !== 3'b100) $display("FAIL async_reset got=%b exp=100", {req_ready, resp_valid, bus_valid}); else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1; bus_rvalid = 1'b1; bus_rdata = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1;
      if (i == 2) bus_rvalid = 1'b0;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL reset_abandon got resp_valid seen=%b exp=0", seen); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", req_ready); else n_pass++;
  endtask

  task automatic test_misalign();
    logic [31:0] v;
    v = $urandom;
    run_op(2, 1'b0, 1'b1, 32'h1002, v, 5'd1, 32'h0, 0, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_checks++; if (o_bus_seen !== 1'b0) $display("FAIL sw_mis_bus got bus_valid seen=%b exp=0", o_bus_seen); else n_pass++;
    n_checks++; if ({o_fault, o_rd_en, o_lat} !== {1'b1, 1'b0, 32'd1}) $display("FAIL sw_mis_fault got fault=%b en=%b lat=%0d exp 1/0/1", o_fault, o_rd_en, o_lat); else n_pass++;
    n_checks++; if ({o_fault_extra, o_after_ok} !== 2'b01) $display("FAIL sw_mis_pulse got=%b exp=01", {o_fault_extra, o_after_ok}); else n_pass++;
`else
    n_checks++; if ({o_addr, o_wstrb} !== {32'h1000, 4'hF}) $display("FAIL sw_align got addr=%h wstrb=%b exp 1000/1111", o_addr, o_wstrb); else n_pass++;
    n_checks++; if (o_wdata !== v) $display("FAIL sw_wdata got=%h exp=%h", o_wdata, v); else n_pass++;
    n_checks++; if ({o_fault, o_fault_extra, o_lat} !== {2'b00, 32'd2}) $display("FAIL sw_nofault got fault=%b extra=%b lat=%0d exp 0/0/2", o_fault, o_fault_extra, o_lat); else n_pass++;
`endif
  endtask

  task automatic test_random();
    int w, rdy, rv, lat;
    logic sgn, we, same, mis;
    logic [31:0] a, v, d;
    rv_reg_t rd;
    for (int k = 0; k < 40; k++) begin
      w = $urandom_range(0, 2); sgn = 1'($urandom); we = 1'($urandom); same = 1'($urandom);
      a = $urandom; v = $urandom; d = $urandom; rd = rv_reg_t'($urandom);
      rdy = $urandom_range(0, 3); rv = $urandom_range(0, 3);
      mis = m_misaligned(w, a);
      lat = mis ? 1 : (we || same) ? rdy + 2 : rdy + rv + 3;
      run_op(w, sgn, we, a, v, rd, d, rdy, rv, same);
      n_checks++; if (o_lat !== lat) $display("FAIL rnd%0d_latency got=%0d exp=%0d", k, o_lat, lat); else n_pass++;
      n_checks++; if ({o_after_ok, o_unstable, o_ready_hi, o_fault_extra} !== 4'b1000)
        $display("FAIL rnd%0d_proto got after/unstable/ready/fault=%b exp=1000", k, {o_after_ok, o_unstable, o_ready_hi, o_fault_extra}); else n_pass++;
      n_checks++; if (o_fault !== mis) $display("FAIL rnd%0d_fault got=%b exp=%b", k, o_fault, mis); else n_pass++;
      if (mis) begin
        n_checks++; if ({o_bus_seen, o_rd_en} !== 2'b00) $display("FAIL rnd%0d_mis got bus=%b en=%b exp 0/0", k, o_bus_seen, o_rd_en); else n_pass++;
      end else begin
        n_checks++;
        if ({o_addr, o_we} !== {a & 32'hFFFFFFFC, we}) $display("FAIL rnd%0d_addr got=%h/%b exp=%h/%b", k, o_addr, o_we, a & 32'hFFFFFFFC, we);
        else n_pass++;
        n_checks++;
        if ({o_wstrb, o_wdata} !== (we ? {m_wstrb(w, a), m_wdata(w, v)} : 36'h0))
          $display("FAIL rnd%0d_wlane got=%b/%h exp=%b/%h", k, o_wstrb, o_wdata, we ? m_wstrb(w, a) : 4'h0, we ? m_wdata(w, v) : 32'h0);
        else n_pass++;
        n_checks++;
        if ({o_rd_en, o_resp_data} !== (we ? 33'h0 : {1'b1, m_load(w, sgn, a, d)}))
          $display("FAIL rnd%0d_resp got en=%b data=%h exp en=%b data=%h", k, o_rd_en, o_resp_data, !we, we ? 32'h0 : m_load(w, sgn, a, d));
        else n_pass++;
        if (!we) begin
          n_checks++; if (o_rd !== rd) $display("FAIL rnd%0d_rd got=%0d exp=%0d", k, o_rd, rd); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_byte();
    test_load_half_stall();
    test_load_word_same_cycle();
    test_reset_mid();
    test_misalign();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
